// File: rtl/cpu_bus_controller_if.sv
// CPU-side request/response bus plus the PPU and external target buses of the controller.
interface cpu_bus_controller_if;
  logic [15:0] cpu_address_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_write_i;
  logic        cpu_valid_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_valid_o;
  logic        cpu_busy_o;
  logic [2:0]  ppu_address_o;
  logic [7:0]  ppu_data_o;
  logic        ppu_write_o;
  logic        ppu_req_o;
  logic [7:0]  ppu_data_i;
  logic        ppu_ack_i;
  logic [15:0] ext_address_o;
  logic [7:0]  ext_data_o;
  logic        ext_write_o;
  logic        ext_req_o;
  logic [7:0]  ext_data_i;
  logic        ext_ack_i;

  // Controller side: serves the CPU and drives the PPU/external targets.
  modport slave (
    input  cpu_address_i, cpu_data_i, cpu_write_i, cpu_valid_i,
    output cpu_data_o, cpu_valid_o, cpu_busy_o,
    output ppu_address_o, ppu_data_o, ppu_write_o, ppu_req_o,
    input  ppu_data_i, ppu_ack_i,
    output ext_address_o, ext_data_o, ext_write_o, ext_req_o,
    input  ext_data_i, ext_ack_i
  );

  // Environment side: CPU issuing requests and the targets answering them.
  modport master (
    output cpu_address_i, cpu_data_i, cpu_write_i, cpu_valid_i,
    input  cpu_data_o, cpu_valid_o, cpu_busy_o,
    input  ppu_address_o, ppu_data_o, ppu_write_o, ppu_req_o,
    output ppu_data_i, ppu_ack_i,
    input  ext_address_o, ext_data_o, ext_write_o, ext_req_o,
    output ext_data_i, ext_ack_i
  );
endinterface

// File: rtl/cpu_bus_controller.sv
// CPU bus controller: decodes requests to internal RAM, PPU registers or the external bus,
// runs the req/ack handshake with timeout and returns a one-cycle completion to the CPU.
module cpu_bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic            clock_i,
  input logic            reset_i,
  cpu_bus_controller_if.slave bus
);
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned PW  = 3;
  localparam int unsigned RW  = 11;
  localparam int unsigned CW  = 8;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RAM, PPU_WAIT, EXT_WAIT, RESPOND} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           wr_q, wr_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic [DW-1:0]  resp_q, resp_d;
  logic           upd_q, upd_d;
  logic           ram_sel_q, ram_sel_d;
  logic [DW-1:0]  cpu_data_q, cpu_data_d;
  logic           cpu_valid_q, cpu_valid_d;
  logic           cpu_busy_q, cpu_busy_d;
  logic [PW-1:0]  ppu_addr_q, ppu_addr_d;
  logic [DW-1:0]  ppu_data_q, ppu_data_d;
  logic           ppu_wr_q, ppu_wr_d;
  logic           ppu_req_q, ppu_req_d;
  logic [AW-1:0]  ext_addr_q, ext_addr_d;
  logic [DW-1:0]  ext_data_q, ext_data_d;
  logic           ext_wr_q, ext_wr_d;
  logic           ext_req_q, ext_req_d;

  logic [DW-1:0]  mem [2**RW];
  logic [DW-1:0]  ram_rd_q;
  logic           ram_we_c;

  assign ram_we_c = (state_q == RAM) && wr_q;

  // Internal RAM: mirrored 2 KiB, contents survive reset.
  always_ff @(posedge clock_i) begin
    if (ram_we_c) mem[addr_q[RW-1:0]] <= wdata_q;
    ram_rd_q <= mem[addr_q[RW-1:0]];
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      wait_q      <= '0;
      resp_q      <= '0;
      upd_q       <= 1'b0;
      ram_sel_q   <= 1'b0;
      cpu_data_q  <= '0;
      cpu_valid_q <= 1'b0;
      cpu_busy_q  <= 1'b0;
      ppu_addr_q  <= '0;
      ppu_data_q  <= '0;
      ppu_wr_q    <= 1'b0;
      ppu_req_q   <= 1'b0;
      ext_addr_q  <= '0;
      ext_data_q  <= '0;
      ext_wr_q    <= 1'b0;
      ext_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      wait_q      <= wait_d;
      resp_q      <= resp_d;
      upd_q       <= upd_d;
      ram_sel_q   <= ram_sel_d;
      cpu_data_q  <= cpu_data_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_busy_q  <= cpu_busy_d;
      ppu_addr_q  <= ppu_addr_d;
      ppu_data_q  <= ppu_data_d;
      ppu_wr_q    <= ppu_wr_d;
      ppu_req_q   <= ppu_req_d;
      ext_addr_q  <= ext_addr_d;
      ext_data_q  <= ext_data_d;
      ext_wr_q    <= ext_wr_d;
      ext_req_q   <= ext_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    wait_d      = wait_q;
    resp_d      = resp_q;
    upd_d       = upd_q;
    ram_sel_d   = ram_sel_q;
    cpu_data_d  = cpu_data_q;
    cpu_valid_d = 1'b0;
    cpu_busy_d  = cpu_busy_q;
    ppu_addr_d  = ppu_addr_q;
    ppu_data_d  = ppu_data_q;
    ppu_wr_d    = ppu_wr_q;
    ppu_req_d   = ppu_req_q;
    ext_addr_d  = ext_addr_q;
    ext_data_d  = ext_data_q;
    ext_wr_d    = ext_wr_q;
    ext_req_d   = ext_req_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_valid_i) begin
          addr_d     = bus.cpu_address_i;
          wdata_d    = bus.cpu_data_i;
          wr_d       = bus.cpu_write_i;
          wait_d     = '0;
          upd_d      = 1'b0;
          ram_sel_d  = 1'b0;
          cpu_busy_d = 1'b1;
          if (bus.cpu_address_i[15:13] == 3'd0)      state_d = RAM;
          else if (bus.cpu_address_i[15:13] == 3'd1) state_d = PPU_WAIT;
          else                                       state_d = EXT_WAIT;
        end
      end
      RAM: begin
        upd_d     = 1'b1;
        ram_sel_d = !wr_q;
        resp_d    = wdata_q;
        state_d   = RESPOND;
      end
      PPU_WAIT: begin
        // First cycle in the state launches the request; acks before that are ignored.
        if (!ppu_req_q) begin
          ppu_req_d  = 1'b1;
          ppu_addr_d = addr_q[PW-1:0];
          ppu_data_d = wr_q ? wdata_q : '0;
          ppu_wr_d   = wr_q;
        end else if (bus.ppu_ack_i || (wait_q == WAIT_LAST)) begin
          upd_d      = bus.ppu_ack_i;
          resp_d     = wr_q ? wdata_q : bus.ppu_data_i;
          ppu_req_d  = 1'b0;
          ppu_addr_d = '0;
          ppu_data_d = '0;
          ppu_wr_d   = 1'b0;
          state_d    = RESPOND;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      EXT_WAIT: begin
        if (!ext_req_q) begin
          ext_req_d  = 1'b1;
          ext_addr_d = addr_q;
          ext_data_d = wr_q ? wdata_q : '0;
          ext_wr_d   = wr_q;
        end else if (bus.ext_ack_i || (wait_q == WAIT_LAST)) begin
          upd_d      = bus.ext_ack_i;
          resp_d     = wr_q ? wdata_q : bus.ext_data_i;
          ext_req_d  = 1'b0;
          ext_addr_d = '0;
          ext_data_d = '0;
          ext_wr_d   = 1'b0;
          state_d    = RESPOND;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      RESPOND: begin
        cpu_valid_d = 1'b1;
        cpu_busy_d  = 1'b0;
        if (upd_q) cpu_data_d = ram_sel_q ? ram_rd_q : resp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_data_o    = cpu_data_q;
  assign bus.cpu_valid_o   = cpu_valid_q;
  assign bus.cpu_busy_o    = cpu_busy_q;
  assign bus.ppu_address_o = ppu_addr_q;
  assign bus.ppu_data_o    = ppu_data_q;
  assign bus.ppu_write_o   = ppu_wr_q;
  assign bus.ppu_req_o     = ppu_req_q;
  assign bus.ext_address_o = ext_addr_q;
  assign bus.ext_data_o    = ext_data_q;
  assign bus.ext_write_o   = ext_wr_q;
  assign bus.ext_req_o     = ext_req_q;
endmodule

// File: tb/tb_cpu_bus_controller.sv
// Directed bench for cpu_bus_controller: RAM mirroring, PPU wait, external timeout,
// external write, ignored requests and mid-transaction reset.
module tb_cpu_bus_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  cpu_bus_controller_if bus ();

  cpu_bus_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle request; returns in cycle T (just after the accepting edge).
  task automatic request(input logic [15:0] a, input logic [7:0] d, input logic w);
    bus.cpu_address_i = a;
    bus.cpu_data_i    = d;
    bus.cpu_write_i   = w;
    bus.cpu_valid_i   = 1'b1;
    tick();
    bus.cpu_valid_i   = 1'b0;
    bus.cpu_address_i = '0;
    bus.cpu_data_i    = '0;
    bus.cpu_write_i   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cpu_data"},  16'(bus.cpu_data_o), 16'h0);
    check({tag, " cpu_valid"}, 16'(bus.cpu_valid_o), 16'h0);
    check({tag, " cpu_busy"},  16'(bus.cpu_busy_o), 16'h0);
    check({tag, " ppu_out"},   16'({bus.ppu_req_o, bus.ppu_write_o, bus.ppu_address_o, bus.ppu_data_o}), 16'h0);
    check({tag, " ext_ctl"},   16'({bus.ext_req_o, bus.ext_write_o, bus.ext_data_o}), 16'h0);
    check({tag, " ext_addr"},  bus.ext_address_o, 16'h0);
  endtask

  initial begin
    bus.cpu_address_i = '0;
    bus.cpu_data_i    = '0;
    bus.cpu_write_i   = 1'b0;
    bus.cpu_valid_i   = 1'b0;
    bus.ppu_data_i    = '0;
    bus.ppu_ack_i     = 1'b0;
    bus.ext_data_i    = '0;
    bus.ext_ack_i     = 1'b0;

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Write 0xA5 to 0x0123 on the first edge after reset release.
    request(16'h0123, 8'hA5, 1'b1);
    check("ramw busy T", 16'(bus.cpu_busy_o), 16'h1);
    tick();
    check("ramw valid T+1", 16'(bus.cpu_valid_o), 16'h0);
    check("ramw targets idle", 16'({bus.ppu_req_o, bus.ext_req_o}), 16'h0);
    tick();
    check("ramw valid T+2", 16'(bus.cpu_valid_o), 16'h1);
    check("ramw data", 16'(bus.cpu_data_o), 16'h00A5);
    check("ramw busy clr", 16'(bus.cpu_busy_o), 16'h0);

    // Mirrored read of 0x1923 issued in the cycle right after completion.
    request(16'h1923, 8'h00, 1'b0);
    check("ramr prev valid drop", 16'(bus.cpu_valid_o), 16'h0);
    tick();
    check("ramr valid T+1", 16'(bus.cpu_valid_o), 16'h0);
    tick();
    check("ramr valid T+2", 16'(bus.cpu_valid_o), 16'h1);
    check("ramr mirror data", 16'(bus.cpu_data_o), 16'h00A5);
    tick();
    check("ramr valid one pulse", 16'(bus.cpu_valid_o), 16'h0);

    // PPU read of 0x3FFE; an early ack before req is ignored, real ack in 3rd req cycle.
    request(16'h3FFE, 8'h00, 1'b0);
    bus.ppu_ack_i  = 1'b1;
    bus.ppu_data_i = 8'h99;
    tick();
    bus.ppu_ack_i  = 1'b0;
    check("ppu req T+1", 16'(bus.ppu_req_o), 16'h1);
    check("ppu addr", 16'(bus.ppu_address_o), 16'h6);
    check("ppu write", 16'(bus.ppu_write_o), 16'h0);
    check("ppu ext idle", 16'({bus.ext_req_o, bus.ext_write_o}), 16'h0);
    tick();
    check("ppu req T+2", 16'(bus.ppu_req_o), 16'h1);
    tick();
    check("ppu req T+3", 16'(bus.ppu_req_o), 16'h1);
    bus.ppu_ack_i  = 1'b1;
    bus.ppu_data_i = 8'h42;
    tick();
    bus.ppu_ack_i  = 1'b0;
    bus.ppu_data_i = 8'h00;
    check("ppu req drop T+4", 16'(bus.ppu_req_o), 16'h0);
    check("ppu addr idle", 16'(bus.ppu_address_o), 16'h0);
    check("ppu valid T+4", 16'(bus.cpu_valid_o), 16'h0);
    tick();
    check("ppu valid T+5", 16'(bus.cpu_valid_o), 16'h1);
    check("ppu data", 16'(bus.cpu_data_o), 16'h0042);

    // External read of 0x8000 that never acks: timeout after 4 req cycles.
    request(16'h8000, 8'h00, 1'b0);
    check("ext to req T", 16'(bus.ext_req_o), 16'h0);
    tick();
    check("ext to req T+1", 16'(bus.ext_req_o), 16'h1);
    check("ext to addr", bus.ext_address_o, 16'h8000);
    tick();
    tick();
    tick();
    check("ext to req T+4", 16'(bus.ext_req_o), 16'h1);
    check("ext to valid T+4", 16'(bus.cpu_valid_o), 16'h0);
    tick();
    check("ext to req drop T+5", 16'(bus.ext_req_o), 16'h0);
    check("ext to valid T+5", 16'(bus.cpu_valid_o), 16'h0);
    tick();
    check("ext to valid T+6", 16'(bus.cpu_valid_o), 16'h1);
    check("ext to open bus", 16'(bus.cpu_data_o), 16'h0042);
    tick();
    check("ext to one pulse", 16'(bus.cpu_valid_o), 16'h0);

    // External write 0x77 to 0x4016, acked in the first req cycle.
    request(16'h4016, 8'h77, 1'b1);
    tick();
    check("extw req", 16'(bus.ext_req_o), 16'h1);
    check("extw write", 16'(bus.ext_write_o), 16'h1);
    check("extw data", 16'(bus.ext_data_o), 16'h0077);
    check("extw addr", bus.ext_address_o, 16'h4016);
    bus.ext_ack_i = 1'b1;
    tick();
    bus.ext_ack_i = 1'b0;
    check("extw idle", 16'({bus.ext_req_o, bus.ext_write_o, bus.ext_data_o}), 16'h0);
    check("extw valid T+2", 16'(bus.cpu_valid_o), 16'h0);
    tick();
    check("extw valid T+3", 16'(bus.cpu_valid_o), 16'h1);
    check("extw data back", 16'(bus.cpu_data_o), 16'h0077);

    // PPU read with a second request during the wait, then reset mid-wait.
    request(16'h2001, 8'h00, 1'b0);
    bus.cpu_address_i = 16'h4000;
    bus.cpu_data_i    = 8'h55;
    bus.cpu_write_i   = 1'b1;
    bus.cpu_valid_i   = 1'b1;
    tick();
    bus.cpu_valid_i   = 1'b0;
    check("rst ppu req", 16'(bus.ppu_req_o), 16'h1);
    check("rst ppu addr", 16'(bus.ppu_address_o), 16'h1);
    check("rst 2nd ignored", 16'({bus.ext_req_o, bus.ppu_write_o}), 16'h0);
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("async rst");
    tick();
    check("rst no valid", 16'(bus.cpu_valid_o), 16'h0);
    rst = 1'b0;

    request(16'h0923, 8'h00, 1'b0);
    check("post rst busy", 16'(bus.cpu_busy_o), 16'h1);
    tick();
    tick();
    check("post rst valid", 16'(bus.cpu_valid_o), 16'h1);
    check("post rst ram data", 16'(bus.cpu_data_o), 16'h00A5);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
